// File: rtl/seq_mult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_mult_pkg
// Description : Shared definitions for the sequential Booth multiplier.
//               Holds the FSM state type and the default operand width.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package seq_mult_pkg;

  // Default operand / result width in bits.
  localparam int c_DEFAULT_WIDTH = 32;

  // Controller states, explicitly encoded.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : seq_mult_pkg
`default_nettype wire

// File: rtl/booth_step.sv
`default_nettype none
// ============================================================================
// Module      : booth_step
// Description : One radix-2 Booth iteration, purely combinational.
//               Decodes {multiplier LSB, previous bit}, adds/subtracts the
//               sign-extended multiplicand into the accumulator, then
//               arithmetic-shifts the {acc, mult, prev} register right by one.
// Parameters  : WIDTH      - operand width (even, >= 4)
// Ports       : acc        in  [WIDTH:0]   current accumulator (one guard bit)
//               mult       in  [WIDTH-1:0] current multiplier/low product bits
//               prev       in  1           previously shifted-out multiplier bit
//               mcand      in  [WIDTH-1:0] multiplicand
//               acc_next   out [WIDTH:0]   accumulator after add and shift
//               mult_next  out [WIDTH-1:0] multiplier after shift
//               prev_next  out 1           new previous bit
// Revision    : 1.0 - initial release
// ============================================================================
module booth_step
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = c_DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] mult,
  input  logic             prev,
  input  logic [WIDTH-1:0] mcand,
  output logic [WIDTH:0]   acc_next,
  output logic [WIDTH-1:0] mult_next,
  output logic             prev_next
);

  // The extra guard bit keeps +/- 2^(WIDTH-1) partial sums representable.
  logic [WIDTH:0] w_mcand_ext;
  logic [WIDTH:0] w_sum;

  assign w_mcand_ext = {mcand[WIDTH-1], mcand};

  always_comb begin
    w_sum = acc;
    unique case ({mult[0], prev})
      2'b10:   w_sum = acc - w_mcand_ext;
      2'b01:   w_sum = acc + w_mcand_ext;
      default: w_sum = acc;
    endcase
  end

  // Arithmetic right shift of the concatenated {sum, mult, prev} register.
  assign acc_next  = {w_sum[WIDTH], w_sum[WIDTH:1]};
  assign mult_next = {w_sum[0], mult[WIDTH-1:1]};
  assign prev_next = mult[0];

endmodule : booth_step
`default_nettype wire

// File: rtl/seq_mult.sv
`default_nettype none
// ============================================================================
// Module      : seq_mult
// Description : Sequential signed multiplier, one radix-2 Booth step per
//               clock. Fixed latency regardless of operand values.
//               Optional macro SEQ_MULT_HI_EN adds the out_hi port carrying
//               the upper WIDTH bits of the 2*WIDTH signed product.
// Parameters  : WIDTH  - operand/result width (even, >= 4)
// Ports       : clk    in  1       clock, rising edge
//               rst    in  1       synchronous active-high reset
//               start  in  1       request; honoured only in IDLE or DONE
//               A      in  WIDTH   signed multiplicand
//               B      in  WIDTH   signed multiplier
//               busy   out 1       high while iterating
//               done   out 1       one-cycle result-valid pulse
//               out    out WIDTH   low WIDTH bits of A*B, held between results
//               out_hi out WIDTH   high WIDTH bits (SEQ_MULT_HI_EN only)
// Revision    : 1.0 - initial release
// ============================================================================
module seq_mult
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = c_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out
`ifdef SEQ_MULT_HI_EN
  ,
  output logic [WIDTH-1:0] out_hi
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH:0]   r_acc;
  logic [WIDTH-1:0] r_mult;
  logic [WIDTH-1:0] r_mcand;
  logic             r_prev;
  logic [CW-1:0]    r_count;

  logic             w_accept;
  logic             w_last_step;
  logic [WIDTH:0]   w_acc_next;
  logic [WIDTH-1:0] w_mult_next;
  logic             w_prev_next;

  booth_step #(
    .WIDTH (WIDTH)
  ) u_booth_step (
    .acc       (r_acc),
    .mult      (r_mult),
    .prev      (r_prev),
    .mcand     (r_mcand),
    .acc_next  (w_acc_next),
    .mult_next (w_mult_next),
    .prev_next (w_prev_next)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and control decode.
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    w_accept     = 1'b0;
    w_last_step  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        // Counter still holds 1 during the WIDTH-th step.
        if (r_count == CW'(1)) begin
          w_last_step  = 1'b1;
          w_state_next = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        // Accepting here gives back-to-back operation with no idle bubble.
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = RUN;
        end else begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc   <= '0;
      r_mult  <= '0;
      r_mcand <= '0;
      r_prev  <= 1'b0;
      r_count <= '0;
      out     <= '0;
`ifdef SEQ_MULT_HI_EN
      out_hi  <= '0;
`endif
    end else if (w_accept) begin
      r_mcand <= A;
      r_mult  <= B;
      r_acc   <= '0;
      r_prev  <= 1'b0;
      r_count <= CW'(WIDTH);
    end else if (r_state == RUN) begin
      r_acc   <= w_acc_next;
      r_mult  <= w_mult_next;
      r_prev  <= w_prev_next;
      r_count <= r_count - CW'(1);
      // Results are captured straight from the final step so they change
      // only on the edge that enters DONE.
      if (w_last_step) begin
        out    <= w_mult_next;
`ifdef SEQ_MULT_HI_EN
        out_hi <= w_acc_next[WIDTH-1:0];
`endif
      end
    end
  end

endmodule : seq_mult
`default_nettype wire

// File: tb/tb_seq_mult.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_mult
// Description : Self-checking bench for seq_mult. A driver issues operations
//               and pushes the expected product and completion cycle into a
//               scoreboard queue; a monitor checks done/busy/out every cycle
//               and pops an entry when its result is due. Expected products
//               come from plain signed 2*WIDTH arithmetic.
//               Macro SEQ_MULT_HI_EN additionally checks out_hi.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_mult;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic [W-1:0] out;
`ifdef SEQ_MULT_HI_EN
  logic [W-1:0] out_hi;
`endif

  always #5 clk = ~clk;

  seq_mult #(
    .WIDTH (W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .out   (out)
`ifdef SEQ_MULT_HI_EN
    ,
    .out_hi(out_hi)
`endif
  );

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    int           due;
  } exp_t;

  exp_t         scoreboard[$];
  int           cyc       = 0;
  int           n_checks  = 0;
  int           n_errors  = 0;
  int           last_due  = 0;
  logic [W-1:0] last_lo   = '0;
  logic [W-1:0] last_hi   = '0;
  bit           m_due;
  bit           m_busy;

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, expv);
    end
  endtask

  // Reference: exact signed product in 2*W bits.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input int due);
    logic signed [2*W-1:0] sa;
    logic signed [2*W-1:0] sbv;
    logic signed [2*W-1:0] p;
    exp_t r;
    sa    = $signed(a);
    sbv   = $signed(b);
    p     = sa * sbv;
    r.lo  = p[W-1:0];
    r.hi  = p[2*W-1:W];
    r.due = due;
    return r;
  endfunction

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (rst) begin
      check("rst_busy", busy, '0);
      check("rst_done", done, '0);
      check("rst_out", out, '0);
`ifdef SEQ_MULT_HI_EN
      check("rst_out_hi", out_hi, '0);
`endif
      last_lo = '0;
      last_hi = '0;
    end else begin
      m_due  = (scoreboard.size() > 0) && (scoreboard[0].due == cyc);
      m_busy = (scoreboard.size() > 0) && (scoreboard[0].due > cyc);
      check("done", done, m_due);
      check("busy", busy, m_busy);
      if (m_due) begin
        last_lo = scoreboard[0].lo;
        last_hi = scoreboard[0].hi;
        void'(scoreboard.pop_front());
        check("out", out, last_lo);
`ifdef SEQ_MULT_HI_EN
        check("out_hi", out_hi, last_hi);
`endif
      end else begin
        check("out_hold", out, last_lo);
`ifdef SEQ_MULT_HI_EN
        check("out_hi_hold", out_hi, last_hi);
`endif
      end
    end
  end

  // Called at a negedge when the DUT is known to be in IDLE or DONE.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    start    = 1'b1;
    A        = a;
    B        = b;
    last_due = cyc + W + 1;
    scoreboard.push_back(model(a, b, last_due));
  endtask

  task automatic drain();
    while (scoreboard.size() > 0) @(negedge clk);
  endtask

  // One operation; optional ignored start pulse and operand noise mid-run.
  task automatic single_op(input logic [W-1:0] a, input logic [W-1:0] b,
                           input int noise_at);
    issue(a, b);
    @(negedge clk);
    start = 1'b0;
    A     = $urandom;
    B     = $urandom;
    if (noise_at > 0) begin
      repeat (noise_at) @(negedge clk);
      start = 1'b1;
      A     = $urandom;
      B     = $urandom;
      @(negedge clk);
      start = 1'b0;
    end
    drain();
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h7FFF_FFFF;
      default: return W'($urandom);
    endcase
  endfunction

  logic [W-1:0] da[6] = '{32'd7, 32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0000,
                          32'd0, 32'h7FFF_FFFF};
  logic [W-1:0] db[6] = '{32'd6, 32'd5, 32'hFFFF_FFFF, 32'h8000_0000,
                          32'h1234_5678, 32'h7FFF_FFFF};
  logic [W-1:0] ba[5] = '{32'd4, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,
                          32'h1357_9BDF};
  logic [W-1:0] bb[5] = '{32'd5, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0003,
                          32'hFEDC_BA98};

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Directed operand corners.
    for (int i = 0; i < 6; i++) begin
      repeat (2) @(negedge clk);
      single_op(da[i], db[i], 0);
    end

    // Start during RUN with new operands must be ignored.
    repeat (2) @(negedge clk);
    single_op(32'd2, 32'd3, 9);

    // Back-to-back with start held high throughout.
    repeat (2) @(negedge clk);
    issue(ba[0], bb[0]);
    for (int i = 1; i < 5; i++) begin
      while (cyc < last_due) @(negedge clk);
      issue(ba[i], bb[i]);
    end
    while (cyc < last_due) @(negedge clk);
    start = 1'b0;
    drain();

    // Reset in the middle of an operation: no done pulse may follow.
    repeat (2) @(negedge clk);
    issue(32'd11, 32'd13);
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    scoreboard.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (W + 4) @(negedge clk);

    // Reset wins over a simultaneous start.
    rst   = 1'b1;
    start = 1'b1;
    A     = 32'd5;
    B     = 32'd5;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    repeat (W + 4) @(negedge clk);

    // Operation after reset completes normally.
    single_op(32'hFFFF_FFF9, 32'd100, 0);

    // Randomized operations, gaps of 0..2 cycles (0 re-issues from DONE).
    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      single_op(pick_operand(), pick_operand(),
                ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 20)) : 0);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_seq_mult
`default_nettype wire
